// File: rtl/tdm_demux_pkg.sv
// Shared constants and types for the TDM demultiplexer.
// The optional mid-frame idle timeout is enabled by TDM_DEMUX_TIMEOUT_EN.
package tdm_demux_pkg;
   localparam int NUM_LANES = 4;
   localparam int SLOT_W    = 2;

   typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_e;
   typedef logic [SLOT_W-1:0] slot_t;

   localparam slot_t LAST_SLOT = slot_t'(NUM_LANES - 1);
endpackage

// File: rtl/tdm_slot_tracker.sv
// Frame alignment tracker: HUNT/RUN state, slot counter, resync and error strobes.
// With TDM_DEMUX_TIMEOUT_EN defined, an idle counter aborts stalled frames.
module tdm_slot_tracker
   import tdm_demux_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   in_valid,
   input  logic   frame_start,
   output slot_t  slot,
   output state_e state,
   output logic   stage_en,
   output slot_t  stage_idx,
   output logic   discard,
   output logic   complete,
   output logic   error
);

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("tdm_slot_tracker: TIMEOUT must be within 1..255");
   end

   state_e state_q, state_d;
   slot_t  slot_q, slot_d;

`ifdef TDM_DEMUX_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
   logic [7:0] idle_q, idle_d;
`endif

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      stage_en  = 1'b0;
      stage_idx = slot_q;
      discard   = 1'b0;
      complete  = 1'b0;
      error     = 1'b0;
`ifdef TDM_DEMUX_TIMEOUT_EN
      idle_d    = '0;
`endif
      if (in_valid) begin
         if (frame_start) begin
            // A start word always opens a fresh frame; mid-frame it is a resync.
            stage_en  = 1'b1;
            stage_idx = '0;
            slot_d    = slot_t'(1);
            state_d   = RUN;
            if (state_q == RUN && slot_q != '0) begin
               error   = 1'b1;
               discard = 1'b1;
            end
         end else if (state_q == RUN) begin
            if (slot_q == '0) begin
               error   = 1'b1;
               state_d = HUNT;
            end else if (slot_q == LAST_SLOT) begin
               complete = 1'b1;
               slot_d   = '0;
            end else begin
               stage_en = 1'b1;
               slot_d   = slot_q + 1'b1;
            end
         end
      end
`ifdef TDM_DEMUX_TIMEOUT_EN
      else if (state_q == RUN && slot_q != '0) begin
         idle_d = idle_q + 8'd1;
         if (idle_d == TIMEOUT_CNT) begin
            error   = 1'b1;
            discard = 1'b1;
            slot_d  = '0;
            state_d = HUNT;
            idle_d  = '0;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= HUNT;
         slot_q  <= '0;
`ifdef TDM_DEMUX_TIMEOUT_EN
         idle_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
`ifdef TDM_DEMUX_TIMEOUT_EN
         idle_q  <= idle_d;
`endif
      end
   end

   assign slot  = slot_q;
   assign state = state_q;

endmodule

// File: rtl/tdm_demultiplexer.sv
// 1:4 TDM demultiplexer: stages slot words and publishes whole frames at once.
// Optional idle timeout via TDM_DEMUX_TIMEOUT_EN (TIMEOUT parameter).
module tdm_demultiplexer
   import tdm_demux_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             frame_start,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic             frame_valid,
   output logic             frame_error,
   output logic             addr0,
   output logic             addr1,
   output logic             locked
);

   slot_t  slot;
   state_e state;
   slot_t  stage_idx;
   logic   stage_en, discard, complete, error;

   tdm_slot_tracker #(.TIMEOUT(TIMEOUT)) u_tracker (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .frame_start (frame_start),
      .slot        (slot),
      .state       (state),
      .stage_en    (stage_en),
      .stage_idx   (stage_idx),
      .discard     (discard),
      .complete    (complete),
      .error       (error)
   );

   // The last lane is never staged: it goes straight from in_data to the output.
   logic [NUM_LANES-2:0][WIDTH-1:0] staging_q, staging_d;
   logic [NUM_LANES-1:0][WIDTH-1:0] out_q, out_d;
   logic                            frame_valid_q, frame_valid_d;
   logic                            frame_error_q, frame_error_d;

   always_comb begin
      staging_d     = staging_q;
      out_d         = out_q;
      frame_valid_d = complete;
      frame_error_d = error;
      if (discard) staging_d = '0;
      if (stage_en) staging_d[stage_idx] = in_data;
      if (complete) begin
         for (int i = 0; i < NUM_LANES - 1; i++) out_d[i] = staging_q[i];
         out_d[NUM_LANES-1] = in_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         staging_q     <= '0;
         out_q         <= '0;
         frame_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         staging_q     <= staging_d;
         out_q         <= out_d;
         frame_valid_q <= frame_valid_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign out0        = out_q[0];
   assign out1        = out_q[1];
   assign out2        = out_q[2];
   assign out3        = out_q[3];
   assign frame_valid = frame_valid_q;
   assign frame_error = frame_error_q;
   assign addr0       = slot[0];
   assign addr1       = slot[1];
   assign locked      = (state == RUN);

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Directed bench for tdm_demultiplexer: expected frames are queued as the last
// word of each frame is driven and compared whenever frame_valid pulses.
module tb_tdm_demultiplexer;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic [0:0] in_data;
   logic       frame_start;
   logic [0:0] out0, out1, out2, out3;
   logic       frame_valid, frame_error, addr0, addr1, locked;

   tdm_demultiplexer #(.WIDTH(1), .TIMEOUT(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .frame_start (frame_start),
      .out0        (out0),
      .out1        (out1),
      .out2        (out2),
      .out3        (out3),
      .frame_valid (frame_valid),
      .frame_error (frame_error),
      .addr0       (addr0),
      .addr1       (addr1),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int sb_checks = 0, sb_errors = 0;
   int fv_cnt = 0;
   logic [3:0] exp_q[$];

   function automatic logic [3:0] outs();
      return {out3, out2, out1, out0};
   endfunction

   // Scoreboard: every frame_valid pulse must match the oldest queued frame.
   always @(negedge clk) begin
      if (frame_valid) begin
         fv_cnt++;
         sb_checks++;
         if (exp_q.size() == 0) begin
            sb_errors++;
            $error("FAIL sb_unexpected_frame: got %h required none", outs());
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            assert (outs() === e) else begin
               sb_errors++;
               $error("FAIL sb_frame: got %h required %h", outs(), e);
            end
         end
      end
      if (frame_valid || frame_error) begin
         sb_checks++;
         assert (!(frame_valid && frame_error)) else begin
            sb_errors++;
            $error("FAIL sb_exclusive: fv=%b fe=%b required not both", frame_valid, frame_error);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   // Drive one accepted word; returns at the next negedge with outputs updated.
   task automatic word(input logic d, input logic fs);
      in_valid    = 1'b1;
      in_data     = d;
      frame_start = fs;
      @(negedge clk);
      in_valid    = 1'b0;
      frame_start = 1'b0;
      in_data     = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_data = 1'b0; frame_start = 1'b0;
      idle(2);
      check("reset_outs", {28'd0, outs()}, 32'h0);
      check("reset_flags", {28'd0, frame_valid, frame_error, locked, addr1 | addr0}, 32'h0);
      reset_n = 1'b1;
      idle(1);

      // 1: normal frame
      word(1, 1); check("t1_addr1", {addr1, addr0}, 1); check("t1_locked", locked, 1);
      word(0, 0); check("t1_addr2", {addr1, addr0}, 2);
      word(1, 0); check("t1_addr3", {addr1, addr0}, 3); check("t1_no_fv_early", frame_valid, 0);
      exp_q.push_back(4'b1101);
      word(1, 0); check("t1_fv", frame_valid, 1); check("t1_addr0", {addr1, addr0}, 0);
      check("t1_outs", outs(), 4'b1101); check("t1_fe", frame_error, 0);
      idle(1); check("t1_fv_one_cycle", frame_valid, 0);

      // 2: gapped frame
      word(1, 1); idle(3);
      word(0, 0); idle(3); check("t2_hold", outs(), 4'b1101);
      word(1, 0); idle(3); check("t2_fe", frame_error, 0); check("t2_locked", locked, 1);
      exp_q.push_back(4'b1101);
      word(1, 0); check("t2_fv", frame_valid, 1);
      idle(1); check("t2_fv_off", frame_valid, 0);

      // 3: words dropped while hunting
      word(1, 0);                       // slot 0 without fs: fault, back to HUNT
      check("t3_fe_missing", frame_error, 1); check("t3_unlocked", locked, 0);
      word(1, 0); check("t3_hunt_drop", {locked, frame_error}, 0);
      word(0, 1); check("t3_lock", locked, 1);
      word(1, 0); word(0, 0);
      exp_q.push_back(4'b0010);
      word(0, 0); check("t3_fv", frame_valid, 1); check("t3_outs", outs(), 4'b0010);

      // 4: early resync
      word(1, 1); word(1, 0);
      word(0, 1); check("t4_fe", frame_error, 1); check("t4_hold", outs(), 4'b0010);
      check("t4_addr", {addr1, addr0}, 1); check("t4_locked", locked, 1);
      word(0, 0); check("t4_fe_pulse", frame_error, 0);
      word(0, 0);
      exp_q.push_back(4'b1000);
      word(1, 0); check("t4_fv", frame_valid, 1); check("t4_outs", outs(), 4'b1000);

      // 5: missing start after a complete frame
      word(1, 0); check("t5_fe", frame_error, 1); check("t5_locked", locked, 0);
      check("t5_hold", outs(), 4'b1000); check("t5_fv", frame_valid, 0);

`ifdef TDM_DEMUX_TIMEOUT_EN
      // 6: idle timeout (TIMEOUT=4)
      word(1, 1); idle(3);
      check("t6_no_to", frame_error, 0); check("t6_still_locked", locked, 1);
      word(0, 0); check("t6_addr2", {addr1, addr0}, 2);
      idle(3); check("t6_before_to", frame_error, 0);
      idle(1); check("t6_to_fe", frame_error, 1); check("t6_to_unlock", locked, 0);
      check("t6_to_slot", {addr1, addr0}, 0);
      idle(1);
`endif

      // 7: reset mid-frame
      word(0, 1); word(1, 0);
      reset_n = 1'b0;
      #1;
      check("t7_rst_outs", outs(), 0);
      check("t7_rst_flags", {locked, addr1, addr0}, 0);
      @(negedge clk); reset_n = 1'b1;
      idle(1);
      word(0, 1); word(1, 0); word(1, 0);
      exp_q.push_back(4'b0110);
      word(0, 0); check("t7_fv", frame_valid, 1); check("t7_outs", outs(), 4'b0110);

      idle(2);
      check("sb_drained", exp_q.size(), 0);
      check("frame_count", fv_cnt, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks + sb_checks, errors + sb_errors);
      $finish;
   end
endmodule
